// File: rtl/huffman_decoder_canon_if.sv
// rtl/huffman_decoder_canon_if.sv - bit-stream input and symbol output handshakes of the canonical Huffman decoder
interface huffman_decoder_canon_if #(
    parameter int IN_W  = 4,
    parameter int SYM_W = 4
) ();
    localparam int LEN_W = $clog2(IN_W + 1);

    logic             s_valid;
    logic [IN_W-1:0]  s_data;
    logic [LEN_W-1:0] s_len;
    logic             s_ready;
    logic             m_valid;
    logic [SYM_W-1:0] m_data;
    logic             m_ready;

    // Producer of bits / consumer of symbols
    modport master (
        output s_valid, s_data, s_len, m_ready,
        input  s_ready, m_valid, m_data
    );

    // The decoder itself
    modport slave (
        input  s_valid, s_data, s_len, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/huffman_decoder_canon.sv
// rtl/huffman_decoder_canon.sv - table-programmable canonical Huffman decoder with bit buffer, flush and error detect
module huffman_decoder_canon #(
    parameter int MAX_CODE = 9,
    parameter int IN_W     = 4,
    parameter int SYM_W    = 4,
    parameter int NUM_SYM  = 16,
    parameter int BUF_W    = MAX_CODE + IN_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  logic [4:0]                   cfg_addr,
    input  logic [15:0]                  cfg_data,
    input  logic                         flush,
    huffman_decoder_canon_if.slave       bus,
    output logic                         err,
    output logic [$clog2(BUF_W+1)-1:0]   bit_count
);
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int LEN_W = $clog2(IN_W + 1);
    localparam int IDX_W = $clog2(NUM_SYM);
    localparam int LW    = $clog2(MAX_CODE + 1);

    typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_ERR} state_t;

    state_t state;

    // Code tables, indexed by code length; entry 0 is never used
    logic [MAX_CODE-1:0] first_code [0:MAX_CODE];
    logic [MAX_CODE-1:0] code_count [0:MAX_CODE];
    logic [IDX_W-1:0]    base       [0:MAX_CODE];
    logic [SYM_W-1:0]    symbol     [0:NUM_SYM-1];

    // Oldest bit sits at the MSB; bits below bit_count are kept zero
    logic [BUF_W-1:0] buffer;
    logic             ready_q;

    logic                unused_cfg_bits;
    logic                l_addr_ok;
    logic                s_addr_ok;
    logic                hit;
    logic [LW-1:0]       hit_len;
    logic [IDX_W-1:0]    hit_idx;
    logic [MAX_CODE-1:0] code_l;
    logic [MAX_CODE-1:0] diff;
    logic                accept;
    logic                consume;
    logic                invalid;
    logic [LW-1:0]       shift_len;
    logic [BUF_W-1:0]    shifted;
    logic [BUF_W-1:0]    beat;
    logic [CNT_W-1:0]    cnt_after;
    logic [BUF_W-1:0]    buf_run;
    logic [CNT_W-1:0]    cnt_run;

    assign unused_cfg_bits = &{1'b0, cfg_data};

    assign l_addr_ok = (int'(cfg_addr) >= 1) && (int'(cfg_addr) <= MAX_CODE);
    assign s_addr_ok = int'(cfg_addr) < NUM_SYM;

    // Table writes; contents deliberately survive reset so a reset does not force reprogramming
    always_ff @(posedge clk) begin
        if (cfg_we && !en) begin
            case (cfg_sel)
                2'd0: if (l_addr_ok) first_code[cfg_addr[LW-1:0]] <= cfg_data[MAX_CODE-1:0];
                2'd1: if (l_addr_ok) code_count[cfg_addr[LW-1:0]] <= cfg_data[MAX_CODE-1:0];
                2'd2: if (l_addr_ok) base[cfg_addr[LW-1:0]]       <= cfg_data[IDX_W-1:0];
                default: if (s_addr_ok) symbol[cfg_addr[IDX_W-1:0]] <= cfg_data[SYM_W-1:0];
            endcase
        end
    end

    // Parallel length match; walking from longest to shortest lets the shortest hit win
    always_comb begin
        hit     = 1'b0;
        hit_len = '0;
        hit_idx = '0;
        code_l  = '0;
        diff    = '0;
        for (int l = MAX_CODE; l >= 1; l--) begin
            code_l = MAX_CODE'(buffer >> (BUF_W - l));
            diff   = code_l - first_code[l];
            if ((int'(bit_count) >= l) && (diff < code_count[l])) begin
                hit     = 1'b1;
                hit_len = LW'(l);
                hit_idx = IDX_W'(base[l] + IDX_W'(diff));
            end
        end
    end

    assign bus.s_ready = ready_q && !flush;
    assign accept      = bus.s_valid && bus.s_ready;
    assign consume     = (state == ST_RUN) && en && hit && (!bus.m_valid || bus.m_ready);
    assign invalid     = (state == ST_RUN) && !hit && (int'(bit_count) >= MAX_CODE);

    // Consume shifts first, then the new beat lands just below the surviving bits
    always_comb begin
        shift_len = consume ? hit_len : '0;
        shifted   = buffer << shift_len;
        cnt_after = bit_count - CNT_W'(shift_len);
        beat      = {bus.s_data, {MAX_CODE{1'b0}}} << (LEN_W'(IN_W) - bus.s_len);
        buf_run   = accept ? (shifted | (beat >> cnt_after)) : shifted;
        cnt_run   = cnt_after + (accept ? CNT_W'(bus.s_len) : '0);
    end

    // Control FSM with the buffer, output register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CFG;
            buffer      <= '0;
            bit_count   <= '0;
            ready_q     <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            err         <= 1'b0;
        end else begin
            if (consume) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= symbol[hit_idx];
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end

            case (state)
                ST_CFG: begin
                    buffer    <= '0;
                    bit_count <= '0;
                    err       <= 1'b0;
                    ready_q   <= en;
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        state     <= ST_CFG;
                        buffer    <= '0;
                        bit_count <= '0;
                        ready_q   <= 1'b0;
                    end else if (flush) begin
                        buffer    <= '0;
                        bit_count <= '0;
                        ready_q   <= 1'b1;
                    end else begin
                        buffer    <= buf_run;
                        bit_count <= cnt_run;
                        if (invalid) begin
                            state   <= ST_ERR;
                            err     <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            ready_q <= int'(cnt_run) <= (BUF_W - IN_W);
                        end
                    end
                end
                ST_ERR: begin
                    ready_q <= 1'b0;
                    if (!en) begin
                        state     <= ST_CFG;
                        err       <= 1'b0;
                        buffer    <= '0;
                        bit_count <= '0;
                    end
                end
                default: state <= ST_CFG;
            endcase
        end
    end
endmodule
